// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter that puts NUM_PORTS requesters onto one memory bus, one transaction at a time.
// It adds a debug override, a response timeout with a sticky error flag, and per-port response routing.
`timescale 1ns/1ps
module memory_bus_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERROR_DATA = DATA_WIDTH'(32'hDEADBEEF),
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_write_data,
    output logic [NUM_PORTS-1:0]             req_response,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  req_read_data,
    input  logic                             override_en,
    input  logic [IDX_W-1:0]                 override_port,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [DATA_WIDTH-1:0]            mem_write_data,
    input  logic                             mem_response,
    input  logic [DATA_WIDTH-1:0]            mem_read_data,
    output logic                             busy,
    output logic [IDX_W-1:0]                 grant_index,
    output logic                             timeout_error,
    input  logic                             error_clear
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;

    state_t           state;
    logic [IDX_W-1:0] rr;
    logic             op_write;
    logic [31:0]      wait_cnt;

    logic [NUM_PORTS-1:0] eligible;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    int                   cand;

    function automatic logic [NUM_PORTS*DATA_WIDTH-1:0] route_data(
        input logic [IDX_W-1:0]      idx,
        input logic [DATA_WIDTH-1:0] d
    );
        logic [NUM_PORTS*DATA_WIDTH-1:0] v;
        v = '0;
        v[idx*DATA_WIDTH +: DATA_WIDTH] = d;
        return v;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = (req_read[i] | req_write[i]) &&
                          (!override_en || override_port == IDX_W'(i));
        end
    end

    // Search upward from the port after the last winner, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = (int'(rr) + k) % NUM_PORTS;
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            rr             <= IDX_W'(NUM_PORTS - 1);
            grant_index    <= '0;
            op_write       <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            wait_cnt       <= '0;
            req_response   <= '0;
            req_read_data  <= '0;
            timeout_error  <= 1'b0;
        end else begin
            if (error_clear)
                timeout_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        grant_index    <= win_idx;
                        rr             <= win_idx;
                        op_write       <= req_write[win_idx];
                        mem_write      <= req_write[win_idx];
                        mem_read       <= ~req_write[win_idx];
                        mem_address    <= req_address[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        mem_write_data <= req_write_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
                        wait_cnt       <= '0;
                        state          <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 32'd1;
                    if (mem_response) begin
                        mem_read      <= 1'b0;
                        mem_write     <= 1'b0;
                        req_response  <= NUM_PORTS'(1) << grant_index;
                        req_read_data <= route_data(grant_index,
                                                    op_write ? '0 : mem_read_data);
                        state         <= S_RESPOND;
                    end else if (TIMEOUT_CYCLES != 0 &&
                                 wait_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        mem_read      <= 1'b0;
                        mem_write     <= 1'b0;
                        timeout_error <= 1'b1;
                        req_response  <= NUM_PORTS'(1) << grant_index;
                        req_read_data <= route_data(grant_index,
                                                    op_write ? '0 : ERROR_DATA);
                        state         <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    req_response  <= '0;
                    req_read_data <= '0;
                    wait_cnt      <= '0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
- N-port successor to the fixed two-way core/interpreter memory mux in the controller top level.
- Arbitrates NUM_PORTS requesters (interpreter, instruction fetch, data, DMA…) onto one memory bus: round-robin fairness, an exclusive debug override, a response timeout and per-port routing of response and read data.
- Sits between the requesters and Memory; one transaction is outstanding at a time.

Parameters:
- NUM_PORTS, 2, number of requester ports (>=1)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- TIMEOUT_CYCLES, 255, WAIT cycles before abort; 0 disables the timeout
- ERROR_DATA, 32'hDEADBEEF, read data returned on a timed-out read (truncated/zero-extended to DATA_WIDTH)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_read  in  NUM_PORTS  per-port read request, held until response
- req_write  in  NUM_PORTS  per-port write request, held until response
- req_address  in  NUM_PORTS*ADDR_WIDTH  port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_write_data  in  NUM_PORTS*DATA_WIDTH  port i slice, same packing
- req_response  out  NUM_PORTS  one-cycle completion pulse to the granted port
- req_read_data  out  NUM_PORTS*DATA_WIDTH  read data for the granted port; valid only with its req_response
- override_en  in  1  restrict grants to override_port
- override_port  in  $clog2(NUM_PORTS) (min 1)  port allowed while override_en=1
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_WIDTH  latched address
- mem_write_data  out  DATA_WIDTH  latched write data
- mem_response  in  1  memory completion
- mem_read_data  in  DATA_WIDTH  memory read data, valid with mem_response
- busy  out  1  high in every state except IDLE
- grant_index  out  $clog2(NUM_PORTS) (min 1)  current or last granted port
- timeout_error  out  1  sticky abort flag
- error_clear  in  1  clears timeout_error

Behaviour:
- Reset (sync, active-high; also mid-transaction):
  - FSM goes to IDLE; all outputs 0; timeout counter 0.
  - rr pointer set to NUM_PORTS-1, so port 0 wins the first arbitration.
  - In-flight transaction is dropped without a response.
- FSM states: IDLE, WAIT, RESPOND.
- IDLE:
  - A port is eligible if (req_read|req_write) is high and, when override_en=1, its index equals override_port.
  - Winner is the first eligible port searching upward from rr+1, wrapping modulo NUM_PORTS.
  - On a winner:
    - Latch address, write data and operation (write wins if req_read and req_write are both high).
    - Set grant_index and rr to the winner.
    - Assert the mem_read or mem_write strobe registered; go to WAIT.
  - No eligible port: stay in IDLE.
- WAIT:
  - Strobe, address and data are held stable.
  - Counter increments each cycle.
  - mem_response=1: capture mem_read_data (reads; writes return 0), drop the strobe, go to RESPOND.
  - Else, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: drop the strobe, set timeout_error, data=ERROR_DATA for reads (0 for writes), go to RESPOND.
  - mem_response on the timeout cycle counts as a normal completion.
- RESPOND (one cycle):
  - req_response[grant_index]=1; req_read_data slice = captured data; all other slices 0.
  - Go to IDLE; counter cleared.
- Latency: request seen high at edge E → strobe from E+1. Memory responding after k strobe cycles → req_response asserted exactly one cycle after mem_response.
- Requester rules:
  - Hold the request until req_response.
  - Deassert by the cycle after req_response, or a new transaction is started.
  - A request dropped before being granted is simply never granted.
- override_en / override_port changes affect only the next IDLE decision; an in-flight transaction always completes.
- timeout_error: error_clear clears it; simultaneous set and clear → set wins.
- NUM_PORTS=1: arbitration is degenerate; grant_index is constant 0.
- Address/data mux outputs are driven only from latched registers; no combinational path from req_* to mem_*.

Test Plan:
- Single read, NUM_PORTS=2: port1 reads addr 0x10, mem responds 2 cycles later with 0xCAFEBABE → req_response[1] one pulse, req_read_data slice1=0xCAFEBABE, slice0=0, grant_index=1.
- Fairness: ports 0 and 1 request continuously after reset (memory 1-cycle response) → grants 0,1,0,1; no port granted twice while the other is waiting.
- Override: override_en=1, override_port=1, both ports requesting → only port1 granted; clearing override resumes round-robin at port 0.
- Timeout: TIMEOUT_CYCLES=4, memory never responds to a port0 read → strobe high exactly 4 cycles; req_response[0] with 0xDEADBEEF; timeout_error=1 until error_clear.
- Write precedence plus reset: port0 asserts read and write with data 0x12345678 → mem_write=1, mem_read=0. Reset asserted in WAIT → next cycle all outputs 0, no req_response.
- NUM_PORTS=4 wrap: after a grant to port3, requests on ports 0 and 2 → port0 granted first, then port2.
